// File: rtl/bcd_seg_scan_if.sv
// Display-word handshake and multiplexed 7-segment outputs for bcd_seg_scan.
// Handshake: a word moves from master to slave only on a rising clk edge where bcd_valid_i and bcd_ready_o are both 1.
interface bcd_seg_scan_if #(
    parameter int NUM_DIGITS = 10
);
    logic [39:0]           bcd_i;
    logic                  bcd_valid_i;
    logic                  bcd_ready_o;
    logic [6:0]            seg_o;
    logic [NUM_DIGITS-1:0] an_o;
    logic                  frame_done_o;
    logic                  fsm_state;     // 0 = IDLE, 1 = SCAN

    modport master (
        output bcd_i,
        output bcd_valid_i,
        input  bcd_ready_o,
        input  seg_o,
        input  an_o,
        input  frame_done_o,
        input  fsm_state
    );

    modport slave (
        input  bcd_i,
        input  bcd_valid_i,
        output bcd_ready_o,
        output seg_o,
        output an_o,
        output frame_done_o,
        output fsm_state
    );
endinterface

// File: rtl/bcd_seg_scan.sv
// Multiplexed BCD 7-segment scanner with a one-entry pending word swapped in only at frame boundaries.
// Optional leading-zero blanking is enabled by defining BCD_SEG_LZB_EN.
module bcd_seg_scan #(
    parameter int NUM_DIGITS = 10,
    parameter int PRESCALE   = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd_seg_scan_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = $clog2(PRESCALE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PS_W-1:0]  LAST_PS  = PS_W'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [PS_W-1:0]       ps_cnt;
    logic [IDX_W-1:0]      idx;
    logic [39:0]           pending;
    logic [39:0]           disp;
    logic                  pending_full;
    logic                  pending_full_next;
    logic                  ready_r;
    logic                  accept;
    logic                  boundary;
    logic                  load_disp;
    logic [3:0]            cur_digit;
    logic                  digit_on;
    logic [6:0]            seg_r;
    logic [NUM_DIGITS-1:0] an_r;
    logic                  frame_done_r;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign accept   = bus.bcd_valid_i && ready_r;
    assign boundary = (state == SCAN) && (ps_cnt == LAST_PS) && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // SCAN is only left through reset; the display word changes only on a boundary.
    always_comb begin
        state_next = state;
        load_disp  = 1'b0;
        case (state)
            IDLE: begin
                if (pending_full) begin
                    load_disp  = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (boundary && pending_full) begin
                    load_disp = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps_cnt <= '0;
            idx    <= '0;
        end else if (state == IDLE) begin
            ps_cnt <= '0;
            idx    <= '0;
        end else if (ps_cnt == LAST_PS) begin
            ps_cnt <= '0;
            idx    <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    // accept needs an empty slot and load_disp needs a full one, so they never coincide:
    // a word taken on a boundary cycle always waits for the next boundary.
    always_comb begin
        pending_full_next = pending_full;
        if (load_disp) begin
            pending_full_next = 1'b0;
        end
        if (accept) begin
            pending_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending      <= '0;
            disp         <= '0;
            pending_full <= 1'b0;
            ready_r      <= 1'b1;
        end else begin
            if (load_disp) begin
                disp <= pending;
            end
            if (accept) begin
                pending <= bus.bcd_i;
            end
            pending_full <= pending_full_next;
            ready_r      <= !pending_full_next;
        end
    end

    always_comb begin
        cur_digit = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_digit = disp[4*k +: 4];
            end
        end
    end

`ifdef BCD_SEG_LZB_EN
    logic [IDX_W-1:0] msd;

    // Highest non-zero digit wins; an all-zero word keeps only digit 0 lit.
    always_comb begin
        msd = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (disp[4*k +: 4] != 4'h0) begin
                msd = IDX_W'(k);
            end
        end
    end

    assign digit_on = (idx <= msd);
`else
    assign digit_on = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_r        <= 7'h7F;
            an_r         <= '1;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= boundary;
            if (state == SCAN && digit_on) begin
                seg_r <= seg_decode(cur_digit);
                an_r  <= ~(NUM_DIGITS'(1) << idx);
            end else begin
                seg_r <= 7'h7F;
                an_r  <= '1;
            end
        end
    end

    assign bus.bcd_ready_o  = ready_r;
    assign bus.seg_o        = seg_r;
    assign bus.an_o         = an_r;
    assign bus.frame_done_o = frame_done_r;
    assign bus.fsm_state    = (state == SCAN);
endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan: expected per-cycle {frame_done, an, seg} frames are queued when a word is offered
// and popped each cycle while the DUT scans.
module tb_bcd_seg_scan;
    localparam int ND    = 10;
    localparam int PS    = 4;
    localparam int FRAME = ND * PS;
`ifdef BCD_SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_seg_scan_if #(.NUM_DIGITS(ND)) bus ();

    bcd_seg_scan #(.NUM_DIGITS(ND), .PRESCALE(PS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    // {care_seg, frame_done, an[9:0], seg[6:0]}
    logic [18:0] exp_q[$];

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    task automatic push_frame(input logic [39:0] w);
        int msd;
        logic shown;
        logic [9:0] an;
        logic [6:0] seg;
        msd = 0;
        for (int k = 0; k < ND; k++) begin
            if (w[4*k +: 4] != 4'h0) msd = k;
        end
        for (int k = 0; k < ND; k++) begin
            shown = !LZB || (k <= msd);
            an    = shown ? ~(10'd1 << k) : 10'h3FF;
            seg   = shown ? seg_ref(w[4*k +: 4]) : 7'h7F;
            for (int c = 0; c < PS; c++) begin
                exp_q.push_back({shown, (k == ND - 1) && (c == PS - 1), an, seg});
            end
        end
    endtask

    task automatic check_frames(input int n, input string name);
        logic [18:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s cycle %0d: queue empty", name, i);
            end else begin
                e = exp_q.pop_front();
                if (bus.an_o !== e[16:7] || bus.frame_done_o !== e[17] ||
                    (e[18] && bus.seg_o !== e[6:0])) begin
                    bad++;
                    $display("FAIL %s cycle %0d: got an=%h seg=%b fd=%b want an=%h seg=%b fd=%b",
                             name, i, bus.an_o, bus.seg_o, bus.frame_done_o, e[16:7], e[6:0], e[17]);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.bcd_valid_i = 1'b0;
        bus.bcd_i = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // Returns at the negedge just before the first displayed digit appears.
    task automatic accept_word(input logic [39:0] w, input string name);
        @(negedge clk);
        total++;
        if (bus.bcd_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready_before: got %b want 1", name, bus.bcd_ready_o);
        end
        bus.bcd_i = w;
        bus.bcd_valid_i = 1'b1;
        @(negedge clk);
        bus.bcd_valid_i = 1'b0;
        total++;
        if (bus.bcd_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_ready_after: got %b want 0", name, bus.bcd_ready_o);
        end
        @(negedge clk);
        total++;
        if (bus.an_o !== 10'h3FF || bus.bcd_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_load: got an=%h ready=%b want an=3ff ready=1", name, bus.an_o, bus.bcd_ready_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (bus.an_o !== 10'h3FF || bus.seg_o !== 7'h7F || bus.bcd_ready_o !== 1'b1 ||
                bus.frame_done_o !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: got an=%h seg=%h ready=%b fd=%b want 3ff 7f 1 0",
                         i, bus.an_o, bus.seg_o, bus.bcd_ready_o, bus.frame_done_o);
            end
        end
    endtask

    task automatic test_scan();
        do_reset();
        accept_word(40'h0000000123, "scan");
        push_frame(40'h0000000123);
        push_frame(40'h0000000123);
        check_frames(2 * FRAME, "scan");
    endtask

    task automatic test_dash();
        do_reset();
        accept_word(40'h000000A000, "dash");
        push_frame(40'h000000A000);
        check_frames(FRAME, "dash");
    endtask

    task automatic test_random();
        logic [39:0] w;
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < ND; k++) w[4*k +: 4] = 4'($urandom_range(0, 15));
            if (t == 2) w[39:16] = '0;
            do_reset();
            accept_word(w, "rand");
            push_frame(w);
            check_frames(FRAME, "rand");
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        accept_word(40'h0000000111, "b2b_a");
        push_frame(40'h0000000111);
        push_frame(40'h0000004567);
        push_frame(40'h0000089000);
        fork
            check_frames(3 * FRAME, "b2b");
            begin
                repeat (10) @(negedge clk);
                total++;
                if (bus.bcd_ready_o !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_b_ready: got %b want 1", bus.bcd_ready_o);
                end
                bus.bcd_i = 40'h0000004567;
                bus.bcd_valid_i = 1'b1;
                @(negedge clk);
                total++;
                if (bus.bcd_ready_o !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_b_taken: got %b want 0", bus.bcd_ready_o);
                end
                bus.bcd_i = 40'h0000089000;
                n = 0;
                while (bus.bcd_ready_o !== 1'b1 && n < 60) begin
                    @(negedge clk);
                    n++;
                end
                total++;
                if (n != 29) begin
                    bad++;
                    $display("FAIL b2b_ready_rise: got %0d cycles want 29", n);
                end
                @(negedge clk);
                bus.bcd_valid_i = 1'b0;
                total++;
                if (bus.bcd_ready_o !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_c_taken: got %b want 0", bus.bcd_ready_o);
                end
            end
        join
    endtask

    task automatic test_reset_mid();
        do_reset();
        accept_word(40'h0000000987, "mid");
        push_frame(40'h0000000987);
        check_frames(15, "mid_pre");
        @(negedge clk);
        bus.bcd_i = 40'h0000000555;
        bus.bcd_valid_i = 1'b1;
        @(negedge clk);
        bus.bcd_valid_i = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (bus.an_o !== 10'h3FF || bus.seg_o !== 7'h7F || bus.bcd_ready_o !== 1'b1 ||
            bus.frame_done_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got an=%h seg=%h ready=%b fd=%b want 3ff 7f 1 0",
                     bus.an_o, bus.seg_o, bus.bcd_ready_o, bus.frame_done_o);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            total++;
            if (bus.an_o !== 10'h3FF || bus.frame_done_o !== 1'b0) begin
                bad++;
                $display("FAIL mid_discard cycle %0d: got an=%h fd=%b want 3ff 0", i, bus.an_o, bus.frame_done_o);
            end
        end
    endtask

    initial begin
        bus.bcd_i = '0;
        bus.bcd_valid_i = 1'b0;
        test_reset();
        test_scan();
        test_dash();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
